// File: rtl/maxpool2x2_stream.sv
// rtl/maxpool2x2_stream.sv - streaming 2x2/stride-2 signed max-pool stage
// Optional stall counter port stall_cnt enabled by MAXPOOL_STALL_CNT_EN.
module maxpool2x2_stream #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 16,
    parameter int IMG_H  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
`ifdef MAXPOOL_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int HW = IMG_W / 2;
    localparam int LW = (HW > 1) ? $clog2(HW) : 1;

    logic [CW-1:0]            col_q, col_d;
    logic [RW-1:0]            row_q, row_d;
    logic signed [DATA_W-1:0] pair_q, pair_d;
    logic                     out_valid_q, out_valid_d;
    logic signed [DATA_W-1:0] out_data_q, out_data_d;
    logic                     out_last_q, out_last_d;
    logic signed [DATA_W-1:0] linebuf_q [HW];

    logic                     accept, col_last, row_last, lb_we;
    logic [LW-1:0]            lb_idx;
    logic signed [DATA_W-1:0] px, pm, lb_rd, win;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign col_last = (col_q == CW'(IMG_W - 1));
    assign row_last = (row_q == RW'(IMG_H - 1));

    // Column pair index into the half-width buffer of even-row pair maxima
    assign lb_idx = LW'(col_q >> 1);
    assign px     = $signed(in_data);
    assign pm     = (pair_q > px) ? pair_q : px;
    assign lb_rd  = linebuf_q[lb_idx];
    assign win    = (lb_rd > pm) ? lb_rd : pm;

    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        pair_d      = pair_q;
        out_valid_d = out_valid_q && !out_ready;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        lb_we       = 1'b0;
        if (accept) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
            if (!col_q[0]) begin
                pair_d = px;
            end else if (!row_q[0]) begin
                lb_we = 1'b1;
            end else begin
                // A new window result overwrites any output being drained this cycle
                out_valid_d = 1'b1;
                out_data_d  = win;
                out_last_d  = row_last && col_last;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q       <= '0;
            row_q       <= '0;
            pair_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            pair_q      <= pair_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    always_ff @(posedge clk) begin
        if (lb_we) begin
            linebuf_q[lb_idx] <= pm;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

`ifdef MAXPOOL_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else if (out_valid_q && !out_ready && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// tb/tb_maxpool2x2_stream.sv - self-checking bench for maxpool2x2_stream
// Three instances (4x2, 4x4, 16x16) share one driver; sel picks the active one.
module tb_maxpool2x2_stream;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       out_ready = 1'b1;
    int         sel = 0;

    logic       in_ready, out_valid, out_last;
    logic [7:0] out_data;
    logic [2:0] iv, ir, ov, ol;
    logic [7:0] od [3];
`ifdef MAXPOOL_STALL_CNT_EN
    logic [15:0] sc [3];
    logic [15:0] stall_cnt;
    assign stall_cnt = sc[sel];
`endif

    always #5 clk = ~clk;

    for (genvar k = 0; k < 3; k++) begin : g_iv
        assign iv[k] = in_valid && (sel == k);
    end

    assign in_ready  = ir[sel];
    assign out_valid = ov[sel];
    assign out_data  = od[sel];
    assign out_last  = ol[sel];

    maxpool2x2_stream #(.DATA_W(8), .IMG_W(4), .IMG_H(2)) u_4x2 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(in_data),
        .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .out_last(ol[0])
`ifdef MAXPOOL_STALL_CNT_EN
        , .stall_cnt(sc[0])
`endif
    );
    maxpool2x2_stream #(.DATA_W(8), .IMG_W(4), .IMG_H(4)) u_4x4 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(in_data),
        .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .out_last(ol[1])
`ifdef MAXPOOL_STALL_CNT_EN
        , .stall_cnt(sc[1])
`endif
    );
    maxpool2x2_stream #(.DATA_W(8), .IMG_W(16), .IMG_H(16)) u_16x16 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(in_data),
        .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]), .out_last(ol[2])
`ifdef MAXPOOL_STALL_CNT_EN
        , .stall_cnt(sc[2])
`endif
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic signed [7:0] fr [256];
    int                pos = 0;
    logic [8:0]        exp_q [$];
    logic [7:0]        got_d [$];
    bit                got_l [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Raster model: keep the whole frame, emit max of the 4 pixels when a window completes
    task automatic model_accept(input logic [7:0] d);
        int mw, mh, r, c;
        logic signed [7:0] m;
        mw = (sel == 2) ? 16 : 4;
        mh = (sel == 0) ? 2 : ((sel == 1) ? 4 : 16);
        fr[pos] = d;
        r = pos / mw;
        c = pos % mw;
        if ((r % 2 == 1) && (c % 2 == 1)) begin
            m = fr[pos];
            if (fr[pos - 1] > m) m = fr[pos - 1];
            if (fr[pos - mw] > m) m = fr[pos - mw];
            if (fr[pos - mw - 1] > m) m = fr[pos - mw - 1];
            exp_q.push_back({pos == mw * mh - 1, m});
        end
        pos = (pos + 1) % (mw * mh);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            pos = 0;
        end else begin
            chk("in_ready_rule", 32'(in_ready), 32'(!out_valid || out_ready));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 32'(out_data), 32'hFFFF_FFFF);
                end else begin
                    chk("out_last_data", {23'd0, out_last, out_data}, {23'd0, exp_q[0]});
                    if (out_ready) exp_q.pop_front();
                end
                if (out_ready) begin
                    got_d.push_back(out_data);
                    got_l.push_back(out_last);
                end
            end
            if (in_valid && in_ready) model_accept(in_data);
        end
    end

    task automatic send(input int v);
        int  n;
        bit  acc;
        in_valid = 1'b1;
        in_data  = 8'(v);
        n = 0;
        forever begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            n++;
            if (n > 100) begin
                chk("send_timeout", 32'(n), 32'd0);
                break;
            end
        end
    endtask

    task automatic do_reset(input int s);
        rst = 1'b1;
        in_valid = 1'b0;
        sel = s;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        got_d.delete();
        got_l.delete();
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
`ifdef MAXPOOL_STALL_CNT_EN
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        in_valid = 1'b0;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_timeout", 32'(n < 300), 32'd1);
    endtask

    int t1 [8] = '{1, 5, -3, 2, 4, 0, 7, -8};
    int start, nl;

    initial begin
        // 1: 4x2 frame, two outputs, last on the second
        do_reset(0);
        out_ready = 1'b1;
        foreach (t1[i]) send(t1[i]);
        drain();
        chk("t1_count", 32'(got_d.size()), 32'd2);
        chk("t1_d0", 32'(got_d[0]), 32'd5);
        chk("t1_d1", 32'(got_d[1]), 32'd7);
        chk("t1_l0", 32'(got_l[0]), 32'd0);
        chk("t1_l1", 32'(got_l[1]), 32'd1);

        // 2: 4x4 frame of the minimum value
        do_reset(1);
        for (int i = 0; i < 16; i++) send(-128);
        drain();
        chk("t2_count", 32'(got_d.size()), 32'd4);
        foreach (got_d[i]) chk("t2_data", 32'(got_d[i]), 32'h80);
        chk("t2_last", 32'(got_l[3]), 32'd1);

        // 3: backpressure on the first output
        do_reset(0);
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) send(t1[i]);
        in_valid = 1'b1;
        in_data  = 8'(t1[6]);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_in_ready", 32'(in_ready), 32'd0);
            chk("t3_out_valid", 32'(out_valid), 32'd1);
            chk("t3_hold_data", 32'(out_data), 32'd5);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(t1[6]);
        send(t1[7]);
        drain();
        chk("t3_count", 32'(got_d.size()), 32'd2);
        chk("t3_d0", 32'(got_d[0]), 32'd5);
        chk("t3_d1", 32'(got_d[1]), 32'd7);

        // 4: two back-to-back 16x16 frames at full rate
        do_reset(2);
        start = cyc;
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < 256; i++) send(i * 37 + f * 91 + 3);
        chk("t4_no_gap_cycles", 32'(cyc - start), 32'd512);
        drain();
        chk("t4_count", 32'(got_d.size()), 32'd128);
        nl = 0;
        foreach (got_l[i]) if (got_l[i]) nl++;
        chk("t4_last_count", 32'(nl), 32'd2);
        chk("t4_last63", 32'(got_l[63]), 32'd1);
        chk("t4_last127", 32'(got_l[127]), 32'd1);

        // 5: reset mid-frame, then a clean 0..15 frame
        do_reset(1);
        for (int i = 0; i < 9; i++) send(119 + i);
        do_reset(1);
        for (int i = 0; i < 16; i++) send(i);
        drain();
        chk("t5_count", 32'(got_d.size()), 32'd4);
        chk("t5_d0", 32'(got_d[0]), 32'd5);
        chk("t5_d1", 32'(got_d[1]), 32'd7);
        chk("t5_d2", 32'(got_d[2]), 32'd13);
        chk("t5_d3", 32'(got_d[3]), 32'd15);
        chk("t5_last", 32'(got_l[3]), 32'd1);

`ifdef MAXPOOL_STALL_CNT_EN
        // 6: stall counter, 10 cycles then saturation
        do_reset(1);
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) send(i);
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("t6_stall10", 32'(stall_cnt), 32'd10);
        do_reset(1);
        for (int i = 0; i < 6; i++) send(i);
        repeat (70000) @(posedge clk);
        @(negedge clk);
        chk("t6_stall_sat", 32'(stall_cnt), 32'hFFFF);
        out_ready = 1'b1;
        drain();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
